// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan controller: digit count and
// active-low segment codes {a,b,c,d,e,f,g,dp}.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'b0000_0011;
  localparam logic [7:0] SEG_1 = 8'b1001_1111;
  localparam logic [7:0] SEG_2 = 8'b0010_0101;
  localparam logic [7:0] SEG_3 = 8'b0000_1101;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b0100_1001;
  localparam logic [7:0] SEG_6 = 8'b0100_0001;
  localparam logic [7:0] SEG_7 = 8'b0001_1111;
  localparam logic [7:0] SEG_8 = 8'b0000_0001;
  localparam logic [7:0] SEG_9 = 8'b0001_1001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decode; non-BCD codes blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of an 8-digit common-anode display with a
// double-buffered BCD frame that swaps only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 200000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num_data,
  input  logic [7:0]  digit_mask,
  input  logic        load,
  output logic        load_ack,
  output logic [7:0]  seg_out,
  output logic [7:0]  dig_en
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]                 slot_cnt;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    active_data, pend_data;
  logic [NUM_DIGITS-1:0]         active_mask, pend_mask;
  logic                          pending;

  logic                          slot_wrap, frame_end, in_guard;
  logic [3:0]                    cur_bcd;
  logic [7:0]                    cur_seg, dig_next, seg_next;

  assign slot_wrap = (slot_cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_wrap && (idx == IW'(NUM_DIGITS - 1));
  assign in_guard  = (slot_cnt < CW'(GUARD));
  assign cur_bcd   = active_data[idx];

  seg7_decode u_decode (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  always_comb begin
    dig_next = 8'hFF;
    seg_next = SEG_BLANK;
    if (!in_guard) begin
      seg_next = cur_seg;
      if (active_mask[idx]) dig_next = ~(8'b1 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A load landing on the boundary cycle refills pending after the swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_data <= '0;
      active_mask <= '0;
      pend_data   <= '0;
      pend_mask   <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      load_ack <= frame_end && pending;
      if (frame_end && pending) begin
        active_data <= pend_data;
        active_mask <= pend_mask;
        pending     <= 1'b0;
      end
      if (load) begin
        pend_data <= num_data;
        pend_mask <= digit_mask;
        pending   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en  <= 8'hFF;
      seg_out <= SEG_BLANK;
    end else begin
      dig_en  <= dig_next;
      seg_out <= seg_next;
    end
  end

endmodule
